// File: rtl/l1d_package.sv
// Shared L1D line-fill parameters, bus payload structs and FSM state encoding.
package l1d_package;

    localparam int unsigned L1D_MSHR_ENTRY_NUM    = 8;
    localparam int unsigned L1D_MSHR_ID_WIDTH     = 3;
    localparam int unsigned L1D_LF_BEAT_NUM       = 4;
    localparam int unsigned L1D_BUS_DATA_WIDTH    = 128;
    localparam int unsigned L1D_LF_BEAT_CNT_WIDTH = $clog2(L1D_LF_BEAT_NUM);
    localparam int unsigned L1D_LINE_DATA_WIDTH   = L1D_LF_BEAT_NUM * L1D_BUS_DATA_WIDTH;
    localparam int unsigned L1D_TAG_WIDTH         = 20;
    localparam int unsigned L1D_INDEX_WIDTH       = 6;
    localparam int unsigned L1D_WAY_WIDTH         = 2;
    localparam int unsigned L1D_OFFSET_WIDTH      = $clog2(L1D_LINE_DATA_WIDTH / 8);
    localparam int unsigned L1D_ADDR_WIDTH        = L1D_TAG_WIDTH + L1D_INDEX_WIDTH + L1D_OFFSET_WIDTH;

    typedef struct packed {
        logic [L1D_TAG_WIDTH-1:0]   tag;
        logic [L1D_INDEX_WIDTH-1:0] index;
        logic [L1D_WAY_WIDTH-1:0]   way;
    } pack_l1d_mshr_downstream_req_pld;

    typedef struct packed {
        logic [L1D_INDEX_WIDTH-1:0]     index;
        logic [L1D_WAY_WIDTH-1:0]       way;
        logic [L1D_LINE_DATA_WIDTH-1:0] data;
        logic                           err;
    } pack_l1d_lf_wr_pld;

    typedef enum logic {
        S_RECV  = 1'b0,
        S_WRITE = 1'b1
    } l1d_lf_state_e;

endpackage

// File: rtl/l1d_lf_ot_table.sv
// Per-MSHR-id outstanding table: valid bit plus the index/way captured at AR time.
module l1d_lf_ot_table
    import l1d_package::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_vld,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]  set_id,
    input  logic [L1D_INDEX_WIDTH-1:0]    set_index,
    input  logic [L1D_WAY_WIDTH-1:0]      set_way,
    input  logic                          clr_vld,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]  clr_id,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]  rd_id,
    output logic [L1D_MSHR_ENTRY_NUM-1:0] ot_vld,
    output logic [L1D_INDEX_WIDTH-1:0]    rd_index,
    output logic [L1D_WAY_WIDTH-1:0]      rd_way
);

    logic [L1D_MSHR_ENTRY_NUM-1:0] set_en;
    logic [L1D_MSHR_ENTRY_NUM-1:0] clr_en;
    logic [L1D_INDEX_WIDTH-1:0]    index_q [L1D_MSHR_ENTRY_NUM];
    logic [L1D_WAY_WIDTH-1:0]      way_q   [L1D_MSHR_ENTRY_NUM];

    v_en_decoder #(.NUM(L1D_MSHR_ENTRY_NUM), .ID_W(L1D_MSHR_ID_WIDTH)) u_set_dec (
        .en  (set_vld),
        .id  (set_id),
        .dec (set_en)
    );

    v_en_decoder #(.NUM(L1D_MSHR_ENTRY_NUM), .ID_W(L1D_MSHR_ID_WIDTH)) u_clr_dec (
        .en  (clr_vld),
        .id  (clr_id),
        .dec (clr_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ot_vld <= '0;
        end else begin
            ot_vld <= (ot_vld & ~clr_en) | set_en;
        end
    end

    // Entry payload is only meaningful while its valid bit is set, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(L1D_MSHR_ENTRY_NUM); i++) begin
            if (set_en[i]) begin
                index_q[i] <= set_index;
                way_q[i]   <= set_way;
            end
        end
    end

    assign rd_index = index_q[rd_id];
    assign rd_way   = way_q[rd_id];

endmodule

// File: rtl/v_en_decoder.sv
// One-hot enable decoder: drives dec[id] with en, all other bits low.
module v_en_decoder #(
    parameter int unsigned NUM  = 8,
    parameter int unsigned ID_W = 3
) (
    input  logic            en,
    input  logic [ID_W-1:0] id,
    output logic [NUM-1:0]  dec
);

    always_comb begin
        dec     = '0;
        dec[id] = en;
    end

endmodule

// File: rtl/l1d_linefill_ctrl.sv
// L1D line-fill controller: issues bus reads for MSHR misses, gathers returned
// beats into a line buffer and writes the completed line into the data RAM.
module l1d_linefill_ctrl
    import l1d_package::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            downstream_req_vld,
    output logic                            downstream_req_rdy,
    input  pack_l1d_mshr_downstream_req_pld downstream_req_pld,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]    downstream_req_id,
    output logic                            bus_ar_vld,
    input  logic                            bus_ar_rdy,
    output logic [L1D_ADDR_WIDTH-1:0]       bus_ar_addr,
    output logic [L1D_MSHR_ID_WIDTH-1:0]    bus_ar_id,
    input  logic                            bus_r_vld,
    output logic                            bus_r_rdy,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]    bus_r_id,
    input  logic [L1D_BUS_DATA_WIDTH-1:0]   bus_r_data,
    input  logic                            bus_r_err,
    input  logic                            bus_r_last,
    output logic                            lf_wr_vld,
    input  logic                            lf_wr_rdy,
    output pack_l1d_lf_wr_pld               lf_wr_pld,
    output logic                            linefill_done_en,
    output logic [L1D_MSHR_ID_WIDTH-1:0]    linefill_done_id,
    output logic                            lf_proto_err
);

    localparam int unsigned CNT_W = L1D_LF_BEAT_CNT_WIDTH;

    l1d_lf_state_e                  state_q, state_d;
    logic [CNT_W-1:0]               beat_cnt_q, beat_cnt_d;
    logic [L1D_MSHR_ID_WIDTH-1:0]   line_id_q, line_id_d;
    logic                           err_q, err_d;
    logic                           drop_q, drop_d;
    logic                           orphan_q, orphan_d;
    logic                           proto_err_q, proto_err_d;
    logic                           done_en_q, done_en_d;
    logic [L1D_MSHR_ID_WIDTH-1:0]   done_id_q, done_id_d;

    logic [L1D_MSHR_ENTRY_NUM-1:0]  ot_vld;
    logic [L1D_INDEX_WIDTH-1:0]     rd_index;
    logic [L1D_WAY_WIDTH-1:0]       rd_way;
    logic [L1D_BUS_DATA_WIDTH-1:0]  line_buf [L1D_LF_BEAT_NUM];
    logic [L1D_LINE_DATA_WIDTH-1:0] line_data;

    logic                           ar_blocked;
    logic                           ar_hs;
    logic                           r_hs;
    logic                           beat0;
    logic                           at_max;
    logic                           line_end;
    logic [L1D_MSHR_ID_WIDTH-1:0]   cur_id;
    logic                           cur_orphan;
    logic                           cur_err;
    logic                           buf_we;

    // AR channel is a pass-through gated only by the outstanding bit of the requested id.
    assign ar_blocked         = ot_vld[downstream_req_id];
    assign bus_ar_vld         = downstream_req_vld & ~ar_blocked;
    assign downstream_req_rdy = bus_ar_rdy & ~ar_blocked;
    assign ar_hs              = downstream_req_vld & downstream_req_rdy;
    assign bus_ar_addr        = {downstream_req_pld.tag, downstream_req_pld.index,
                                 L1D_OFFSET_WIDTH'(0)};
    assign bus_ar_id          = downstream_req_id;

    l1d_lf_ot_table u_ot_table (
        .clk       (clk),
        .rst       (rst),
        .set_vld   (ar_hs),
        .set_id    (downstream_req_id),
        .set_index (downstream_req_pld.index),
        .set_way   (downstream_req_pld.way),
        .clr_vld   (done_en_q),
        .clr_id    (done_id_q),
        .rd_id     (line_id_q),
        .ot_vld    (ot_vld),
        .rd_index  (rd_index),
        .rd_way    (rd_way)
    );

    assign bus_r_rdy  = (state_q == S_RECV) & ~rst;
    assign r_hs       = bus_r_vld & bus_r_rdy;
    assign beat0      = (beat_cnt_q == '0);
    assign at_max     = (beat_cnt_q == CNT_W'(L1D_LF_BEAT_NUM - 1));
    assign line_end   = bus_r_last | at_max;
    // Line identity is taken from the first beat only; later beats reuse the latched copy.
    assign cur_id     = beat0 ? bus_r_id : line_id_q;
    assign cur_orphan = beat0 ? ~ot_vld[bus_r_id] : orphan_q;
    assign cur_err    = (beat0 ? 1'b0 : err_q) | bus_r_err;
    assign buf_we     = r_hs & ~drop_q & ~cur_orphan;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RECV;
            beat_cnt_q  <= '0;
            line_id_q   <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            orphan_q    <= 1'b0;
            proto_err_q <= 1'b0;
            done_en_q   <= 1'b0;
            done_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            line_id_q   <= line_id_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            orphan_q    <= orphan_d;
            proto_err_q <= proto_err_d;
            done_en_q   <= done_en_d;
            done_id_q   <= done_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_id_d   = line_id_q;
        err_d       = err_q;
        drop_d      = drop_q;
        orphan_d    = orphan_q;
        proto_err_d = proto_err_q;
        done_en_d   = 1'b0;
        done_id_d   = done_id_q;
        case (state_q)
            S_RECV: begin
                if (r_hs) begin
                    if (drop_q) begin
                        // Surplus beats of an over-long line are swallowed up to its last.
                        if (bus_r_last) begin
                            drop_d = 1'b0;
                        end
                    end else begin
                        line_id_d = cur_id;
                        orphan_d  = cur_orphan;
                        err_d     = cur_err;
                        if (cur_orphan) begin
                            proto_err_d = 1'b1;
                        end
                        if (line_end) begin
                            beat_cnt_d = '0;
                            if (bus_r_last ^ at_max) begin
                                proto_err_d = 1'b1;
                            end
                            if (!bus_r_last) begin
                                drop_d = 1'b1;
                            end
                            if (!cur_orphan) begin
                                state_d = S_WRITE;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            S_WRITE: begin
                if (lf_wr_rdy) begin
                    state_d   = S_RECV;
                    done_en_d = 1'b1;
                    done_id_d = line_id_q;
                end
            end
            default: state_d = S_RECV;
        endcase
    end

    // Line buffer holds data only; stale slots are harmless and need no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[beat_cnt_q] <= bus_r_data;
        end
    end

    always_comb begin
        line_data = '0;
        for (int i = 0; i < int'(L1D_LF_BEAT_NUM); i++) begin
            line_data[i*L1D_BUS_DATA_WIDTH +: L1D_BUS_DATA_WIDTH] = line_buf[i];
        end
    end

    assign lf_wr_vld        = (state_q == S_WRITE);
    assign lf_wr_pld        = '{index: rd_index, way: rd_way, data: line_data, err: err_q};
    assign linefill_done_en = done_en_q;
    assign linefill_done_id = done_id_q;
    assign lf_proto_err     = proto_err_q;

endmodule

// File: tb/tb_l1d_linefill_ctrl.sv
// Randomized scoreboard bench for l1d_linefill_ctrl with a behavioural line-fill model.
module tb_l1d_linefill_ctrl;
    import l1d_package::*;

    localparam int unsigned CW = 528;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            downstream_req_vld;
    logic                            downstream_req_rdy;
    pack_l1d_mshr_downstream_req_pld downstream_req_pld;
    logic [L1D_MSHR_ID_WIDTH-1:0]    downstream_req_id;
    logic                            bus_ar_vld;
    logic                            bus_ar_rdy;
    logic [L1D_ADDR_WIDTH-1:0]       bus_ar_addr;
    logic [L1D_MSHR_ID_WIDTH-1:0]    bus_ar_id;
    logic                            bus_r_vld;
    logic                            bus_r_rdy;
    logic [L1D_MSHR_ID_WIDTH-1:0]    bus_r_id;
    logic [L1D_BUS_DATA_WIDTH-1:0]   bus_r_data;
    logic                            bus_r_err;
    logic                            bus_r_last;
    logic                            lf_wr_vld;
    logic                            lf_wr_rdy;
    pack_l1d_lf_wr_pld               lf_wr_pld;
    logic                            linefill_done_en;
    logic [L1D_MSHR_ID_WIDTH-1:0]    linefill_done_id;
    logic                            lf_proto_err;

    l1d_linefill_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .downstream_req_vld (downstream_req_vld),
        .downstream_req_rdy (downstream_req_rdy),
        .downstream_req_pld (downstream_req_pld),
        .downstream_req_id  (downstream_req_id),
        .bus_ar_vld         (bus_ar_vld),
        .bus_ar_rdy         (bus_ar_rdy),
        .bus_ar_addr        (bus_ar_addr),
        .bus_ar_id          (bus_ar_id),
        .bus_r_vld          (bus_r_vld),
        .bus_r_rdy          (bus_r_rdy),
        .bus_r_id           (bus_r_id),
        .bus_r_data         (bus_r_data),
        .bus_r_err          (bus_r_err),
        .bus_r_last         (bus_r_last),
        .lf_wr_vld          (lf_wr_vld),
        .lf_wr_rdy          (lf_wr_rdy),
        .lf_wr_pld          (lf_wr_pld),
        .linefill_done_en   (linefill_done_en),
        .linefill_done_id   (linefill_done_id),
        .lf_proto_err       (lf_proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding table, line buffer contents and sticky protocol flag.
    bit                              mdl_ot   [L1D_MSHR_ENTRY_NUM];
    logic [L1D_INDEX_WIDTH-1:0]      mdl_idx  [L1D_MSHR_ENTRY_NUM];
    logic [L1D_WAY_WIDTH-1:0]        mdl_way  [L1D_MSHR_ENTRY_NUM];
    logic [L1D_BUS_DATA_WIDTH-1:0]   mdl_buf  [L1D_LF_BEAT_NUM];
    bit                              mdl_proto = 1'b0;
    pack_l1d_lf_wr_pld               exp_wr   [$];
    logic [L1D_MSHR_ID_WIDTH-1:0]    exp_done [$];
    bit                              rand_rdy = 1'b0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented write and every done pulse is matched to the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (lf_wr_vld) begin
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    check("wr_pld", CW'(lf_wr_pld), CW'(exp_wr[0]));
                    if (lf_wr_rdy) void'(exp_wr.pop_front());
                end
            end
            if (linefill_done_en) begin
                if (exp_done.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    check("done_id", CW'(linefill_done_id), CW'(exp_done[0]));
                    mdl_ot[exp_done[0]] = 1'b0;
                    void'(exp_done.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) lf_wr_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_ar(input logic [2:0] id, input logic [5:0] idx, input logic [1:0] way);
        bit ok = 1'b0;
        logic [L1D_TAG_WIDTH-1:0] tag = L1D_TAG_WIDTH'($urandom);
        downstream_req_vld = 1'b1;
        downstream_req_id  = id;
        downstream_req_pld = '{tag: tag, index: idx, way: way};
        bus_ar_rdy         = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (downstream_req_rdy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            fail("ar_timeout");
        end else begin
            check("ar_vld", CW'(bus_ar_vld), CW'(1'b1));
            check("ar_addr", CW'(bus_ar_addr), CW'({tag, idx, 6'd0}));
            check("ar_id", CW'(bus_ar_id), CW'(id));
            tick();
            mdl_ot[id]  = 1'b1;
            mdl_idx[id] = idx;
            mdl_way[id] = way;
        end
        downstream_req_vld = 1'b0;
    endtask

    task automatic send_line(input logic [2:0] id, input int nbeats, input int last_pos, input int err_beat);
        bit ok;
        bit orphan = !mdl_ot[id];
        bit err_acc = 1'b0;
        int eff_end = (last_pos < 3) ? last_pos : 3;
        logic [L1D_BUS_DATA_WIDTH-1:0] d;
        pack_l1d_lf_wr_pld e;
        for (int b = 0; b < nbeats; b++) begin
            d          = {$urandom, $urandom, $urandom, $urandom};
            bus_r_vld  = 1'b1;
            bus_r_id   = (b == 0) ? id : 3'($urandom);
            bus_r_data = d;
            bus_r_err  = (b == err_beat);
            bus_r_last = (b == last_pos);
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (bus_r_rdy) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok) begin
                fail("r_rdy_timeout");
                break;
            end
            tick();
            if (b <= eff_end) begin
                if (!orphan) mdl_buf[b] = d;
                err_acc = err_acc | (b == err_beat);
            end
            if (b == eff_end) begin
                if (orphan || last_pos != 3) mdl_proto = 1'b1;
                if (!orphan) begin
                    e.index = mdl_idx[id];
                    e.way   = mdl_way[id];
                    e.data  = {mdl_buf[3], mdl_buf[2], mdl_buf[1], mdl_buf[0]};
                    e.err   = err_acc;
                    exp_wr.push_back(e);
                    exp_done.push_back(id);
                end
            end
        end
        bus_r_vld  = 1'b0;
        bus_r_last = 1'b0;
        bus_r_err  = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_wr.size() == 0 && exp_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("idle_timeout");
        tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(L1D_MSHR_ENTRY_NUM); i++) mdl_ot[i] = 1'b0;
        mdl_proto = 1'b0;
        exp_wr.delete();
        exp_done.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst                = 1'b1;
        downstream_req_vld = 1'b0;
        downstream_req_pld = '0;
        downstream_req_id  = '0;
        bus_ar_rdy         = 1'b1;
        bus_r_vld          = 1'b0;
        bus_r_id           = '0;
        bus_r_data         = '0;
        bus_r_err          = 1'b0;
        bus_r_last         = 1'b0;
        lf_wr_rdy          = 1'b1;
        model_reset();

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_r_rdy", CW'(bus_r_rdy), CW'(1'b0));
        check("rst_wr_vld", CW'(lf_wr_vld), CW'(1'b0));
        check("rst_done", CW'(linefill_done_en), CW'(1'b0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_r_rdy", CW'(bus_r_rdy), CW'(1'b1));
        check("post_rst_proto", CW'(lf_proto_err), CW'(1'b0));
        check("post_rst_req_rdy", CW'(downstream_req_rdy), CW'(1'b1));
        tick();

        // Single fill with r_last-to-done latency of two cycles
        do_ar(3'd2, 6'h15, 2'd1);
        send_line(3'd2, 4, 3, -1);
        @(negedge clk);
        check("sf_wr_vld", CW'(lf_wr_vld), CW'(1'b1));
        check("sf_r_rdy_low", CW'(bus_r_rdy), CW'(1'b0));
        check("sf_no_early_done", CW'(linefill_done_en), CW'(1'b0));
        tick();
        @(negedge clk);
        check("sf_done", CW'(linefill_done_en), CW'(1'b1));
        check("sf_done_id", CW'(linefill_done_id), CW'(3'd2));
        wait_idle();

        // Write backpressure
        lf_wr_rdy = 1'b0;
        do_ar(3'd3, 6'h2A, 2'd3);
        send_line(3'd3, 4, 3, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_wr_vld", CW'(lf_wr_vld), CW'(1'b1));
            check("bp_r_rdy", CW'(bus_r_rdy), CW'(1'b0));
            check("bp_done", CW'(linefill_done_en), CW'(1'b0));
            tick();
        end
        lf_wr_rdy = 1'b1;
        @(negedge clk);
        check("bp_no_done_yet", CW'(linefill_done_en), CW'(1'b0));
        tick();
        @(negedge clk);
        check("bp_done_after_rdy", CW'(linefill_done_en), CW'(1'b1));
        wait_idle();

        // Duplicate id blocked until two cycles after the write handshake
        do_ar(3'd2, 6'h0A, 2'd2);
        downstream_req_vld = 1'b1;
        downstream_req_id  = 3'd2;
        downstream_req_pld = '{tag: 20'h1234, index: 6'h2B, way: 2'd3};
        bus_ar_rdy         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dup_req_rdy", CW'(downstream_req_rdy), CW'(1'b0));
            check("dup_ar_vld", CW'(bus_ar_vld), CW'(1'b0));
            tick();
        end
        send_line(3'd2, 4, 3, -1);
        @(negedge clk);
        check("dup_rdy_w", CW'(downstream_req_rdy), CW'(1'b0));
        tick();
        @(negedge clk);
        check("dup_done_w1", CW'(linefill_done_en), CW'(1'b1));
        check("dup_rdy_w1", CW'(downstream_req_rdy), CW'(1'b0));
        tick();
        @(negedge clk);
        check("dup_rdy_w2", CW'(downstream_req_rdy), CW'(1'b1));
        check("dup_ar_vld_w2", CW'(bus_ar_vld), CW'(1'b1));
        tick();
        downstream_req_vld = 1'b0;
        mdl_ot[2]  = 1'b1;
        mdl_idx[2] = 6'h2B;
        mdl_way[2] = 2'd3;
        send_line(3'd2, 4, 3, -1);
        wait_idle();

        // Out-of-order return
        do_ar(3'd1, 6'h01, 2'd0);
        do_ar(3'd5, 6'h3F, 2'd3);
        send_line(3'd5, 4, 3, -1);
        send_line(3'd1, 4, 3, -1);
        wait_idle();

        // Bus error on beat 2, then early r_last
        do_ar(3'd4, 6'h10, 2'd2);
        send_line(3'd4, 4, 3, 2);
        wait_idle();
        check("err_no_proto", CW'(lf_proto_err), CW'(1'b0));
        do_ar(3'd6, 6'h11, 2'd1);
        send_line(3'd6, 2, 1, -1);
        wait_idle();
        check("short_proto", CW'(lf_proto_err), CW'(1'b1));

        // Reset in the middle of a line
        do_ar(3'd7, 6'h22, 2'd2);
        send_line(3'd7, 3, 3, -1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_r_rdy", CW'(bus_r_rdy), CW'(1'b0));
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_post_r_rdy", CW'(bus_r_rdy), CW'(1'b1));
        check("mid_post_proto", CW'(lf_proto_err), CW'(1'b0));
        check("mid_post_wr_vld", CW'(lf_wr_vld), CW'(1'b0));
        bus_ar_rdy = 1'b0;
        for (int i = 0; i < int'(L1D_MSHR_ENTRY_NUM); i++) begin
            tick();
            downstream_req_vld = 1'b1;
            downstream_req_id  = 3'(i);
            @(negedge clk);
            check("ot_cleared", CW'(bus_ar_vld), CW'(1'b1));
        end
        tick();
        downstream_req_vld = 1'b0;
        do_ar(3'd7, 6'h23, 2'd0);
        send_line(3'd7, 4, 3, -1);
        wait_idle();
        check("refill_proto", CW'(lf_proto_err), CW'(mdl_proto));

        // Randomized lines: normal, short, long, orphan, with random write backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [2:0] id = 3'($urandom_range(0, 7));
            int sel  = int'($urandom_range(0, 9));
            int lsel = int'($urandom_range(0, 9));
            int lp   = (lsel == 0) ? 1 : (lsel == 1) ? 5 : 3;
            if (!(sel == 0 && !mdl_ot[id]) && !mdl_ot[id]) begin
                do_ar(id, 6'($urandom), 2'($urandom));
            end
            send_line(id, lp + 1, lp, int'($urandom_range(0, 7)));
            wait_idle();
            check("rand_proto", CW'(lf_proto_err), CW'(mdl_proto));
        end
        rand_rdy  = 1'b0;
        lf_wr_rdy = 1'b1;
        wait_idle();
        check("end_wr_queue", CW'(exp_wr.size()), CW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
